// File: rtl/axi_read_protocol.sv
// AXI read-side protocol FSM covering the AR and R channels.
// Turns raw master requests and slave data into protocol-legal axi_ar*/axi_r*
// signals. It allows a single outstanding burst and tracks the beat index,
// the per-beat address and rlast generation.
// Each channel runs a WAIT / COMMIT (valid & ready) / ASSERT (valid, !ready) handshake.

module axi_read_protocol #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 64
) (
  input  logic          axi_aclk,
  input  logic          axi_areset,
  input  logic [AW-1:0] araddr_in,
  input  logic [7:0]    arlen_in,
  input  logic [2:0]    arsize_in,
  input  logic [1:0]    arburst_in,
  input  logic          arvalid_in,
  input  logic [DW-1:0] rdata_in,
  input  logic [1:0]    rresp_in,
  input  logic          rvalid_in,
  input  logic          rready_in,
  output logic [AW-1:0] axi_araddr,
  output logic [7:0]    axi_arlen,
  output logic [2:0]    axi_arsize,
  output logic [1:0]    axi_arburst,
  output logic          axi_arvalid,
  output logic          axi_arready,
  output logic [DW-1:0] axi_rdata,
  output logic [1:0]    axi_rresp,
  output logic          axi_rlast,
  output logic          axi_rvalid,
  output logic          axi_rready,
  output logic          r_active,
  output logic [7:0]    beat_cnt,
  output logic [AW-1:0] beat_addr
);

  typedef enum logic [1:0] {
    StWait   = 2'b00,
    StCommit = 2'b01,
    StAssert = 2'b10
  } state_e;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [1:0] BurstRsvd  = 2'b11;
  localparam logic [1:0] RespSlvErr = 2'b10;

  state_e ar_state_q, ar_state_d;
  state_e r_state_q, r_state_d;

  logic [AW-1:0] araddr_q, araddr_d;
  logic [7:0]    arlen_q, arlen_d;
  logic [2:0]    arsize_q, arsize_d;
  logic [1:0]    arburst_q, arburst_d;
  logic          arvalid_q, arvalid_d;
  logic          arready_q, arready_d;

  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;
  logic          rlast_q, rlast_d;
  logic          rvalid_q, rvalid_d;
  logic          rready_q, rready_d;

  logic          r_active_q, r_active_d;
  logic [7:0]    beat_cnt_q, beat_cnt_d;
  logic [AW-1:0] beat_addr_q, beat_addr_d;

  // Burst attributes latched at the AR handshake; axi_ar* may already hold the next request.
  logic [7:0]    len_q, len_d;
  logic [2:0]    size_q, size_d;
  logic [1:0]    burst_q, burst_d;

  logic [AW-1:0] beat_bytes;
  logic [AW-1:0] incr_addr;
  logic [AW-1:0] wrap_mask;
  logic [AW-1:0] next_addr;
  logic [1:0]    resp_sel;
  logic [7:0]    beat_cnt_inc;

  // Address of the following beat, plus response override for reserved bursts.
  always_comb begin
    beat_bytes   = AW'(1) << size_q;
    incr_addr    = beat_addr_q + beat_bytes;
    wrap_mask    = ((AW'(len_q) + AW'(1)) << size_q) - AW'(1);
    beat_cnt_inc = beat_cnt_q + 8'd1;
    case (burst_q)
      BurstIncr: next_addr = incr_addr;
      BurstWrap: next_addr = (beat_addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default:   next_addr = beat_addr_q;
    endcase
    resp_sel = (burst_q == BurstRsvd) ? RespSlvErr : rresp_in;
  end

  // Next-state and output logic for both channel FSMs.
  always_comb begin
    ar_state_d  = ar_state_q;
    r_state_d   = r_state_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    arsize_d    = arsize_q;
    arburst_d   = arburst_q;
    arvalid_d   = arvalid_q;
    arready_d   = arready_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rlast_d     = rlast_q;
    rvalid_d    = rvalid_q;
    rready_d    = rready_q;
    r_active_d  = r_active_q;
    beat_cnt_d  = beat_cnt_q;
    beat_addr_d = beat_addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;

    // AR channel
    unique case (ar_state_q)
      StWait: begin
        if (arvalid_in) begin
          araddr_d   = araddr_in;
          arlen_d    = arlen_in;
          arsize_d   = arsize_in;
          arburst_d  = arburst_in;
          arvalid_d  = 1'b1;
          arready_d  = !r_active_q;
          ar_state_d = r_active_q ? StAssert : StCommit;
        end else begin
          arready_d = !r_active_q;
        end
      end
      StCommit: begin
        r_active_d  = 1'b1;
        arready_d   = 1'b0;
        len_d       = arlen_q;
        size_d      = arsize_q;
        burst_d     = arburst_q;
        beat_addr_d = araddr_q;
        beat_cnt_d  = 8'd0;
        if (arvalid_in) begin
          // Queue the next request; it waits in ASSERT until this burst ends.
          araddr_d   = araddr_in;
          arlen_d    = arlen_in;
          arsize_d   = arsize_in;
          arburst_d  = arburst_in;
          arvalid_d  = 1'b1;
          ar_state_d = StAssert;
        end else begin
          arvalid_d  = 1'b0;
          ar_state_d = StWait;
        end
      end
      StAssert: begin
        if (!r_active_q) begin
          arready_d  = 1'b1;
          ar_state_d = StCommit;
        end
      end
      default: ar_state_d = StWait;
    endcase

    // R channel; only moves while a burst is active, so it never collides with AR COMMIT.
    unique case (r_state_q)
      StWait: begin
        if (r_active_q && rvalid_in) begin
          rdata_d   = rdata_in;
          rresp_d   = resp_sel;
          rvalid_d  = 1'b1;
          rlast_d   = (beat_cnt_q == len_q);
          rready_d  = rready_in;
          r_state_d = rready_in ? StCommit : StAssert;
        end else begin
          rvalid_d = 1'b0;
          rready_d = rready_in;
        end
      end
      StCommit: begin
        if (rlast_q) begin
          r_active_d = 1'b0;
          beat_cnt_d = 8'd0;
          rvalid_d   = 1'b0;
          rlast_d    = 1'b0;
          r_state_d  = StWait;
        end else begin
          beat_cnt_d  = beat_cnt_inc;
          beat_addr_d = next_addr;
          if (rvalid_in) begin
            rdata_d   = rdata_in;
            rresp_d   = resp_sel;
            rvalid_d  = 1'b1;
            rlast_d   = (beat_cnt_inc == len_q);
            rready_d  = rready_in;
            r_state_d = rready_in ? StCommit : StAssert;
          end else begin
            rvalid_d  = 1'b0;
            r_state_d = StWait;
          end
        end
      end
      StAssert: begin
        if (rready_in) begin
          rready_d  = 1'b1;
          r_state_d = StCommit;
        end
      end
      default: r_state_d = StWait;
    endcase
  end

  // State registers with synchronous reset; arready idles high.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      ar_state_q  <= StWait;
      r_state_q   <= StWait;
      araddr_q    <= '0;
      arlen_q     <= '0;
      arsize_q    <= '0;
      arburst_q   <= BurstFixed;
      arvalid_q   <= 1'b0;
      arready_q   <= 1'b1;
      rdata_q     <= '0;
      rresp_q     <= '0;
      rlast_q     <= 1'b0;
      rvalid_q    <= 1'b0;
      rready_q    <= 1'b0;
      r_active_q  <= 1'b0;
      beat_cnt_q  <= '0;
      beat_addr_q <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= BurstFixed;
    end else begin
      ar_state_q  <= ar_state_d;
      r_state_q   <= r_state_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      arsize_q    <= arsize_d;
      arburst_q   <= arburst_d;
      arvalid_q   <= arvalid_d;
      arready_q   <= arready_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      rlast_q     <= rlast_d;
      rvalid_q    <= rvalid_d;
      rready_q    <= rready_d;
      r_active_q  <= r_active_d;
      beat_cnt_q  <= beat_cnt_d;
      beat_addr_q <= beat_addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
    end
  end

  assign axi_araddr  = araddr_q;
  assign axi_arlen   = arlen_q;
  assign axi_arsize  = arsize_q;
  assign axi_arburst = arburst_q;
  assign axi_arvalid = arvalid_q;
  assign axi_arready = arready_q;
  assign axi_rdata   = rdata_q;
  assign axi_rresp   = rresp_q;
  assign axi_rlast   = rlast_q;
  assign axi_rvalid  = rvalid_q;
  assign axi_rready  = rready_q;
  assign r_active    = r_active_q;
  assign beat_cnt    = beat_cnt_q;
  assign beat_addr   = beat_addr_q;

endmodule

// File: tb/tb_axi_read_protocol.sv
// Directed bench for axi_read_protocol: single beat, INCR, WRAP, backpressure,
// back-to-back requests, reserved burst and mid-burst reset.

module tb_axi_read_protocol;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;

  logic          axi_aclk = 1'b0;
  logic          axi_areset;
  logic [AW-1:0] araddr_in;
  logic [7:0]    arlen_in;
  logic [2:0]    arsize_in;
  logic [1:0]    arburst_in;
  logic          arvalid_in;
  logic [DW-1:0] rdata_in;
  logic [1:0]    rresp_in;
  logic          rvalid_in;
  logic          rready_in;
  logic [AW-1:0] axi_araddr;
  logic [7:0]    axi_arlen;
  logic [2:0]    axi_arsize;
  logic [1:0]    axi_arburst;
  logic          axi_arvalid;
  logic          axi_arready;
  logic [DW-1:0] axi_rdata;
  logic [1:0]    axi_rresp;
  logic          axi_rlast;
  logic          axi_rvalid;
  logic          axi_rready;
  logic          r_active;
  logic [7:0]    beat_cnt;
  logic [AW-1:0] beat_addr;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_addr [8];

  axi_read_protocol #(.AW(AW), .DW(DW)) dut (
    .axi_aclk    (axi_aclk),
    .axi_areset  (axi_areset),
    .araddr_in   (araddr_in),
    .arlen_in    (arlen_in),
    .arsize_in   (arsize_in),
    .arburst_in  (arburst_in),
    .arvalid_in  (arvalid_in),
    .rdata_in    (rdata_in),
    .rresp_in    (rresp_in),
    .rvalid_in   (rvalid_in),
    .rready_in   (rready_in),
    .axi_araddr  (axi_araddr),
    .axi_arlen   (axi_arlen),
    .axi_arsize  (axi_arsize),
    .axi_arburst (axi_arburst),
    .axi_arvalid (axi_arvalid),
    .axi_arready (axi_arready),
    .axi_rdata   (axi_rdata),
    .axi_rresp   (axi_rresp),
    .axi_rlast   (axi_rlast),
    .axi_rvalid  (axi_rvalid),
    .axi_rready  (axi_rready),
    .r_active    (r_active),
    .beat_cnt    (beat_cnt),
    .beat_addr   (beat_addr)
  );

  always #5 axi_aclk = ~axi_aclk;

  // Advance one clock and sample 1ns after the rising edge.
  task automatic tick();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue a request while idle: one-cycle pulse, handshake, then burst starts.
  task automatic issue_ar(input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    araddr_in  = addr;
    arlen_in   = len;
    arsize_in  = size;
    arburst_in = burst;
    arvalid_in = 1'b1;
    tick();
    chk("ar_hs_arvalid", 64'(axi_arvalid), 64'(1));
    chk("ar_hs_arready", 64'(axi_arready), 64'(1));
    arvalid_in = 1'b0;
    tick();
    chk("ar_done_arvalid", 64'(axi_arvalid), 64'(0));
    chk("ar_done_ractive", 64'(r_active), 64'(1));
    chk("ar_done_beat_addr", 64'(beat_addr), 64'(addr));
    chk("ar_done_beat_cnt", 64'(beat_cnt), 64'(0));
  endtask

  // Stream n beats with continuous data and checks each against exp_addr.
  task automatic run_beats(input int n, input logic [63:0] base,
                           input logic [1:0] in_resp, input logic [1:0] exp_resp);
    rready_in = 1'b1;
    rresp_in  = in_resp;
    for (int i = 0; i < n; i++) begin
      rvalid_in = 1'b1;
      rdata_in  = base + 64'(i);
      tick();
      chk("beat_rvalid", 64'(axi_rvalid), 64'(1));
      chk("beat_rdata", axi_rdata, base + 64'(i));
      chk("beat_rresp", 64'(axi_rresp), 64'(exp_resp));
      chk("beat_cnt", 64'(beat_cnt), 64'(i));
      chk("beat_addr", 64'(beat_addr), 64'(exp_addr[i]));
      chk("beat_rlast", 64'(axi_rlast), 64'(i == n - 1));
    end
    rvalid_in = 1'b0;
    tick();
    chk("end_ractive", 64'(r_active), 64'(0));
    chk("end_rvalid", 64'(axi_rvalid), 64'(0));
    chk("end_beat_cnt", 64'(beat_cnt), 64'(0));
    tick();
    chk("end_arready", 64'(axi_arready), 64'(1));
  endtask

  initial begin
    axi_areset = 1'b1;
    araddr_in  = '0;
    arlen_in   = '0;
    arsize_in  = '0;
    arburst_in = '0;
    arvalid_in = 1'b0;
    rdata_in   = '0;
    rresp_in   = '0;
    rvalid_in  = 1'b0;
    rready_in  = 1'b0;
    tick();
    tick();
    chk("rst_arready", 64'(axi_arready), 64'(1));
    chk("rst_arvalid", 64'(axi_arvalid), 64'(0));
    chk("rst_ractive", 64'(r_active), 64'(0));
    chk("rst_rvalid", 64'(axi_rvalid), 64'(0));
    chk("rst_beat_cnt", 64'(beat_cnt), 64'(0));
    axi_areset = 1'b0;
    tick();

    // Single beat INCR
    issue_ar(32'h1000, 8'd0, 3'd3, 2'b01);
    exp_addr[0] = 32'h1000;
    run_beats(1, 64'hA0, 2'b00, 2'b00);

    // INCR len 3 size 3, response passed through
    issue_ar(32'h1000, 8'd3, 3'd3, 2'b01);
    exp_addr[0] = 32'h1000;
    exp_addr[1] = 32'h1008;
    exp_addr[2] = 32'h1010;
    exp_addr[3] = 32'h1018;
    run_beats(4, 64'h100, 2'b01, 2'b01);

    // WRAP len 3 size 2 from 0x1008
    issue_ar(32'h1008, 8'd3, 3'd2, 2'b10);
    exp_addr[0] = 32'h1008;
    exp_addr[1] = 32'h100C;
    exp_addr[2] = 32'h1000;
    exp_addr[3] = 32'h1004;
    run_beats(4, 64'h200, 2'b00, 2'b00);

    // Backpressure on beat 1 of INCR len 2
    issue_ar(32'h2000, 8'd2, 3'd3, 2'b01);
    rready_in = 1'b1;
    rvalid_in = 1'b1;
    rdata_in  = 64'hB0;
    tick();
    chk("bp_beat0_rdata", axi_rdata, 64'hB0);
    rready_in = 1'b0;
    rdata_in  = 64'hB1;
    tick();
    chk("bp_assert_rready", 64'(axi_rready), 64'(0));
    chk("bp_assert_rdata", axi_rdata, 64'hB1);
    chk("bp_assert_cnt", 64'(beat_cnt), 64'(1));
    chk("bp_assert_addr", 64'(beat_addr), 64'h2008);
    rdata_in = 64'hDEAD;
    rresp_in = 2'b11;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bp_hold_rdata", axi_rdata, 64'hB1);
      chk("bp_hold_rresp", 64'(axi_rresp), 64'(0));
      chk("bp_hold_rlast", 64'(axi_rlast), 64'(0));
      chk("bp_hold_cnt", 64'(beat_cnt), 64'(1));
      chk("bp_hold_rready", 64'(axi_rready), 64'(0));
    end
    rready_in = 1'b1;
    rresp_in  = 2'b00;
    rdata_in  = 64'hB2;
    tick();
    chk("bp_commit_rready", 64'(axi_rready), 64'(1));
    chk("bp_commit_rdata", axi_rdata, 64'hB1);
    chk("bp_commit_cnt", 64'(beat_cnt), 64'(1));
    tick();
    chk("bp_beat2_rdata", axi_rdata, 64'hB2);
    chk("bp_beat2_rlast", 64'(axi_rlast), 64'(1));
    chk("bp_beat2_cnt", 64'(beat_cnt), 64'(2));
    chk("bp_beat2_addr", 64'(beat_addr), 64'h2010);
    rvalid_in = 1'b0;
    tick();
    chk("bp_end_ractive", 64'(r_active), 64'(0));
    tick();

    // Back-to-back: second request queued while the first burst runs
    issue_ar(32'h3000, 8'd1, 3'd3, 2'b01);
    araddr_in  = 32'h4000;
    arlen_in   = 8'd0;
    arsize_in  = 3'd2;
    arburst_in = 2'b01;
    arvalid_in = 1'b1;
    tick();
    chk("b2b_q_arvalid", 64'(axi_arvalid), 64'(1));
    chk("b2b_q_arready", 64'(axi_arready), 64'(0));
    chk("b2b_q_araddr", 64'(axi_araddr), 64'h4000);
    arvalid_in = 1'b0;
    araddr_in  = 32'h5555;
    arlen_in   = 8'd9;
    rvalid_in  = 1'b1;
    rready_in  = 1'b1;
    rdata_in   = 64'hC0;
    tick();
    chk("b2b_hold_araddr", 64'(axi_araddr), 64'h4000);
    chk("b2b_hold_arlen", 64'(axi_arlen), 64'(0));
    chk("b2b_hold_arready", 64'(axi_arready), 64'(0));
    rdata_in = 64'hC1;
    tick();
    chk("b2b_last_rlast", 64'(axi_rlast), 64'(1));
    chk("b2b_last_arvalid", 64'(axi_arvalid), 64'(1));
    rvalid_in = 1'b0;
    tick();
    chk("b2b_idle_ractive", 64'(r_active), 64'(0));
    chk("b2b_idle_arready", 64'(axi_arready), 64'(0));
    tick();
    chk("b2b_hs_arready", 64'(axi_arready), 64'(1));
    chk("b2b_hs_arvalid", 64'(axi_arvalid), 64'(1));
    chk("b2b_hs_araddr", 64'(axi_araddr), 64'h4000);
    tick();
    chk("b2b_new_ractive", 64'(r_active), 64'(1));
    chk("b2b_new_beat_addr", 64'(beat_addr), 64'h4000);
    chk("b2b_new_arvalid", 64'(axi_arvalid), 64'(0));
    exp_addr[0] = 32'h4000;
    run_beats(1, 64'hE0, 2'b00, 2'b00);

    // Reserved burst: fixed address and forced SLVERR
    issue_ar(32'h6004, 8'd2, 3'd2, 2'b11);
    exp_addr[0] = 32'h6004;
    exp_addr[1] = 32'h6004;
    exp_addr[2] = 32'h6004;
    run_beats(3, 64'h300, 2'b00, 2'b10);

    // Reset on beat 2 of INCR len 7
    issue_ar(32'h7000, 8'd7, 3'd3, 2'b01);
    rvalid_in = 1'b1;
    rready_in = 1'b1;
    rdata_in  = 64'h77;
    tick();
    tick();
    tick();
    chk("mid_beat2_cnt", 64'(beat_cnt), 64'(2));
    chk("mid_beat2_addr", 64'(beat_addr), 64'h7010);
    axi_areset = 1'b1;
    tick();
    chk("mrst_arready", 64'(axi_arready), 64'(1));
    chk("mrst_arvalid", 64'(axi_arvalid), 64'(0));
    chk("mrst_araddr", 64'(axi_araddr), 64'(0));
    chk("mrst_rvalid", 64'(axi_rvalid), 64'(0));
    chk("mrst_rready", 64'(axi_rready), 64'(0));
    chk("mrst_rdata", axi_rdata, 64'(0));
    chk("mrst_rlast", 64'(axi_rlast), 64'(0));
    chk("mrst_ractive", 64'(r_active), 64'(0));
    chk("mrst_beat_cnt", 64'(beat_cnt), 64'(0));
    chk("mrst_beat_addr", 64'(beat_addr), 64'(0));
    axi_areset = 1'b0;
    rvalid_in  = 1'b0;
    tick();
    issue_ar(32'h8000, 8'd1, 3'd2, 2'b01);
    exp_addr[0] = 32'h8000;
    exp_addr[1] = 32'h8004;
    run_beats(2, 64'h400, 2'b00, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_read_protocol.md
Name: axi_read_protocol

Overview:
- Protocol FSM for the AXI read side: the AR (read address) and R (read data) channels.
- Companion to the team's write-side protocol FSM (AW/W/B). It uses the same three-state handshake model per channel: WAIT, COMMIT (valid and ready both high), ASSERT (valid high, ready low).
- Takes raw master-request and slave-data inputs and drives protocol-legal axi_ar*/axi_r* signals.
- Allows one outstanding read burst, with a beat counter, per-beat address generation and rlast generation.

Parameters:
AW, 32, address width
DW, 64, data width

Ports:
axi_aclk  in  1  global clock
axi_areset  in  1  one clock; reset is synchronous and active-high
araddr_in  in  AW  requested burst start address
arlen_in  in  8  requested burst length minus 1
arsize_in  in  3  requested beat size (bytes = 1<<arsize)
arburst_in  in  2  requested burst type
arvalid_in  in  1  master has a read request
rdata_in  in  DW  slave read data
rresp_in  in  2  slave response
rvalid_in  in  1  slave has a data beat
rready_in  in  1  master can accept a beat
axi_araddr  out  AW  AR address
axi_arlen  out  8  AR length
axi_arsize  out  3  AR size
axi_arburst  out  2  AR burst type
axi_arvalid  out  1  AR valid
axi_arready  out  1  AR ready
axi_rdata  out  DW  R data
axi_rresp  out  2  R response
axi_rlast  out  1  last beat of burst
axi_rvalid  out  1  R valid
axi_rready  out  1  R ready
r_active  out  1  a burst is accepted and not yet completed
beat_cnt  out  8  index of the current beat within the burst
beat_addr  out  AW  address of the current beat

Behaviour:
- State encoding for both FSMs: WAIT=2'b00, COMMIT=2'b01, ASSERT=2'b10.
- Reset (synchronous): all outputs reset to 0 except axi_arready, which resets to 1. Both FSMs return to WAIT. In-flight beats and any pending request are discarded.

AR FSM:
- WAIT, arvalid_in && !r_active: capture the request fields into axi_ar*, set arvalid=1 and arready=1, go to COMMIT.
- WAIT, arvalid_in && r_active: capture fields, set arvalid=1 and arready=0, go to ASSERT.
- WAIT, otherwise: arready <= !r_active.
- COMMIT (exactly 1 cycle; this is the handshake cycle):
  - set r_active=1 and arready=0;
  - load the burst registers len/size/burst from axi_ar*;
  - load beat_addr=axi_araddr and beat_cnt=0;
  - if arvalid_in: capture the new request, keep arvalid=1, go to ASSERT;
  - else arvalid=0, go to WAIT.
- ASSERT: axi_ar* and arvalid are held stable. When r_active==0: arready<=1, go to COMMIT.

R FSM (active only while r_active):
- WAIT, r_active && rvalid_in:
  - capture rdata and rresp, set rvalid=1;
  - rlast = (beat_cnt==len);
  - rready = rready_in;
  - go to COMMIT if rready_in, else ASSERT.
- WAIT, otherwise: rvalid=0, rready<=rready_in. rvalid_in is ignored while !r_active.
- COMMIT (the beat transfers in this cycle):
  - if rlast: r_active<=0, beat_cnt<=0, rvalid<=0, rlast<=0, go to WAIT;
  - else: beat_cnt+1 and beat_addr advances. If rvalid_in, capture the next beat with rlast=(beat_cnt+1==len), rready=rready_in, and go to COMMIT or ASSERT. Otherwise rvalid=0, go to WAIT.
- ASSERT: rdata, rresp and rlast are held stable. When rready_in: rready<=1, go to COMMIT.

r_active ownership:
- Set only in AR COMMIT; cleared only in R COMMIT on the last beat.
- The two cannot coincide, because AR COMMIT requires r_active==0.
- A queued request in AR ASSERT reaches COMMIT no earlier than 2 cycles after the last beat's R COMMIT.

Address arithmetic (bytes = 1<<size, modulo 2^AW):
- FIXED (00): beat_addr unchanged.
- INCR (01): beat_addr + bytes.
- WRAP (10): mask = ((len+1)<<size)-1; next = (beat_addr & ~mask) | ((beat_addr+bytes) & mask).
- Reserved (11): address behaves as FIXED, and every beat's axi_rresp is forced to 2'b10 (SLVERR).
- All other bursts: rresp_in is passed through unchanged.

Test Plan:
- Single beat: addr 0x1000, len 0, size 3, INCR, rvalid_in=rready_in=1.
  -> arvalid&arready high for 1 cycle; one R beat with rlast=1 and beat_addr 0x1000; r_active returns to 0.
- INCR burst: len 3, size 3, start 0x1000, continuous data.
  -> 4 beats with beat_addr 0x1000, 0x1008, 0x1010, 0x1018; rlast only on beat 3; beat_cnt 0..3.
- WRAP burst: len 3, size 2, start 0x1008.
  -> beat_addr 0x1008, 0x100C, 0x1000, 0x1004; rlast on the 4th beat.
- Backpressure: rready_in low 3 cycles on beat 1 of an INCR len 2 burst.
  -> R FSM in ASSERT; axi_rdata/rresp/rlast stable and beat_cnt=1 for 3 cycles; COMMIT the cycle after rready_in rises.
- Back-to-back: second request while r_active=1.
  -> AR in ASSERT with arvalid=1, arready=0 and fields stable until the last beat commits; then COMMIT and new r_active.
- Reserved burst and mid-burst reset:
  - arburst 2'b11 with rresp_in=00 -> every beat has axi_rresp=10 and a constant beat_addr.
  - axi_areset asserted on beat 2 of a len 7 burst -> all outputs at reset values the next cycle (arready=1); a new request completes normally.
